uart_tx_sched: RTL and testbench

Two-requester transmit scheduler for the UART core: arbitrates round-robin between two byte sources and sequences a single serial TX line one bit per `baud_tick` pulse from `baud_tick_gen`. It sits between the host-side byte interfaces and the `tx` pin. The tick generator stays a free-running peer instantiated at the same top level.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_arb2.sv | 20 ++
 rtl/uart_tx_sched.sv | 138 +++++++++++++
 tb/tb_uart_tx_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the TX sequencing states.
// The RX block is expected to reuse the same frame defaults.
package uart_pkg;

    localparam int unsigned UartDataBits = 8;
    localparam int unsigned UartStopBits = 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_rr_arb2.sv
// Combinational two-way round-robin pick.
// When both requesters compete, the one that was not served last wins.
module uart_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_idx = ~last;
        end else begin
            gnt_idx = req1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmit scheduler: round-robin grant on baud ticks,
// then start / data (LSB first) / stop bits, one bit per tick.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UartDataBits,
    parameter int unsigned STOP_BITS = UartStopBits
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [DATA_BITS-1:0] data0,
    input  logic [DATA_BITS-1:0] data1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 tx,
    output logic                 busy,
    output logic                 grant_id
);

    localparam int unsigned CntW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] BitLast = CntW'(DATA_BITS - 1);
    localparam logic StopLast = 1'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic stop_cnt_q, stop_cnt_d;
    logic last_q, last_d;
    logic grant_id_q, grant_id_d;
    logic tx_q, tx_d;
    logic ack0_q, ack0_d;
    logic ack1_q, ack1_d;

    logic gnt_valid;
    logic gnt_idx;
    logic frame_end;
    logic grant;

    uart_rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Grants only land on ticks, so every bit spans a full tick period.
    assign frame_end = baud_tick && (state_q == StStop) && (stop_cnt_q == StopLast);
    assign grant     = baud_tick && gnt_valid && ((state_q == StIdle) || frame_end);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            last_q     <= 1'b1;
            grant_id_q <= 1'b0;
            tx_q       <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            tx_q       <= tx_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StStart;
            StStart: if (baud_tick) state_d = StData;
            StData:  if (baud_tick && (bit_cnt_q == BitLast)) state_d = StStop;
            StStop:  if (frame_end) state_d = grant ? StStart : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        tx_d       = tx_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        if (grant) begin
            shift_d    = gnt_idx ? data1 : data0;
            grant_id_d = gnt_idx;
            last_d     = gnt_idx;
            tx_d       = 1'b0;
            ack0_d     = ~gnt_idx;
            ack1_d     = gnt_idx;
        end else if (baud_tick) begin
            unique case (state_q)
                StStart: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
                StData: begin
                    if (bit_cnt_q != BitLast) begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
                StStop: begin
                    if (stop_cnt_q != StopLast) begin
                        stop_cnt_d = 1'b1;
                    end
                    tx_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_id_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: 20 ns clock, baud_tick every 4 clocks.
// A second instance covers the 7-data / 2-stop frame shape.
module tb_uart_tx_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, tx, busy, grant_id;

    logic       req2;
    logic       req2_b;
    logic [6:0] data2, data2_b;
    logic       ack2_0, ack2_1, tx2, busy2, grant_id2;

    int n_cmp = 0;
    int n_err = 0;
    int ack0_seen = 0;
    int ack1_seen = 0;
    int exp_ack0 = 0;
    int exp_ack1 = 0;
    logic [1:0] tick_phase = 2'd0;

    uart_tx_sched u_dut (
        .clock     (clock),
        .reset     (reset),
        .baud_tick (baud_tick),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    uart_tx_sched #(
        .DATA_BITS (7),
        .STOP_BITS (2)
    ) u_dut2 (
        .clock     (clock),
        .reset     (reset),
        .baud_tick (baud_tick),
        .req0      (req2),
        .req1      (req2_b),
        .data0     (data2),
        .data1     (data2_b),
        .ack0      (ack2_0),
        .ack1      (ack2_1),
        .tx        (tx2),
        .busy      (busy2),
        .grant_id  (grant_id2)
    );

    always #10 clock = ~clock;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tick_phase = tick_phase + 2'd1;
            baud_tick  = (tick_phase == 2'd3);
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            if (ack0 === 1'b1) ack0_seen++;
            if (ack1 === 1'b1) ack1_seen++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns just after a clock edge at which the DUT sampled baud_tick=1.
    task automatic next_tick();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clock);
            if (baud_tick === 1'b1) seen = 1'b1;
        end
        check_eq("tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic expect_grant(input logic id);
        check_eq("grant_tx", 32'(tx), 32'd0);
        check_eq("grant_busy", 32'(busy), 32'd1);
        check_eq("grant_ack0", 32'(ack0), 32'(!id));
        check_eq("grant_ack1", 32'(ack1), 32'(id));
        check_eq("grant_id", 32'(grant_id), 32'(id));
        if (id) exp_ack1++;
        else exp_ack0++;
    endtask

    // Called at the negedge after a grant; ends at the negedge after the stop tick.
    task automatic expect_body(input logic [7:0] d, input int raise1_at);
        @(negedge clock);
        check_eq("ack_width0", 32'(ack0), 32'd0);
        check_eq("ack_width1", 32'(ack1), 32'd0);
        check_eq("start_hold", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            @(negedge clock);
            check_eq("data_bit", 32'(tx), 32'(d[i]));
            check_eq("data_busy", 32'(busy), 32'd1);
            check_eq("data_noack", 32'({ack1, ack0}), 32'd0);
            if (i == raise1_at) begin
                req1  = 1'b1;
                data1 = 8'h99;
            end
        end
        next_tick();
        @(negedge clock);
        check_eq("stop_bit", 32'(tx), 32'd1);
        check_eq("stop_busy", 32'(busy), 32'd1);
    endtask

    task automatic expect_idle_end();
        next_tick();
        @(negedge clock);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_tx", 32'(tx), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int c1;
        logic [6:0] d7;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        req2 = 1'b0; req2_b = 1'b0; data2 = '0; data2_b = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ack", 32'({ack1, ack0}), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_tx2", 32'(tx2), 32'd1);
        check_eq("rst_busy2", 32'(busy2), 32'd0);
        reset = 1'b0;

        // Single frame 0xA5 from requester 0.
        req0 = 1'b1; data0 = 8'hA5;
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0;
        expect_body(8'hA5, -1);
        expect_idle_end();

        // Contention after reset: last=1 so requester 0 wins first.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h55; data1 = 8'h0F;
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0;
        expect_body(8'h55, -1);
        next_tick();
        @(negedge clock);
        expect_grant(1'b1);
        req1 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h81;
        expect_body(8'h0F, -1);
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0; req1 = 1'b0;
        expect_body(8'h81, -1);
        expect_idle_end();

        // Request 1 raised during data bit 3 waits for the frame-end tick.
        req0 = 1'b1; data0 = 8'h3C;
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0;
        c1 = ack1_seen;
        expect_body(8'h3C, 3);
        check_eq("midframe_noack1", 32'(ack1_seen), 32'(c1));
        next_tick();
        @(negedge clock);
        expect_grant(1'b1);
        req1 = 1'b0;
        expect_body(8'h99, -1);
        expect_idle_end();

        // Request between ticks while idle.
        next_tick();
        @(posedge clock);
        #1;
        req0 = 1'b1; data0 = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("between_tx", 32'(tx), 32'd1);
            check_eq("between_busy", 32'(busy), 32'd0);
        end
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0;
        expect_body(8'hC3, -1);
        expect_idle_end();

        // Reset during data bit 5 of an all-zero byte.
        req0 = 1'b1; data0 = 8'h00;
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_tick();
            @(negedge clock);
        end
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ack", 32'({ack1, ack0}), 32'd0);
        reset = 1'b0;
        req0 = 1'b1; data0 = 8'h5A;
        next_tick();
        @(negedge clock);
        expect_grant(1'b0);
        req0 = 1'b0;
        expect_body(8'h5A, -1);
        expect_idle_end();

        // 7 data bits, 2 stop bits: 10 tick periods, last two high.
        d7 = 7'h2B;
        req2 = 1'b1; data2 = d7;
        next_tick();
        @(negedge clock);
        check_eq("s2_start_tx", 32'(tx2), 32'd0);
        check_eq("s2_ack", 32'(ack2_0), 32'd1);
        check_eq("s2_busy", 32'(busy2), 32'd1);
        req2 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            next_tick();
            @(negedge clock);
            check_eq("s2_data_bit", 32'(tx2), 32'(d7[i]));
        end
        for (int i = 0; i < 2; i++) begin
            next_tick();
            @(negedge clock);
            check_eq("s2_stop_tx", 32'(tx2), 32'd1);
            check_eq("s2_stop_busy", 32'(busy2), 32'd1);
        end
        next_tick();
        @(negedge clock);
        check_eq("s2_end_busy", 32'(busy2), 32'd0);
        check_eq("s2_end_tx", 32'(tx2), 32'd1);

        @(negedge clock);
        check_eq("ack0_pulses", 32'(ack0_seen), 32'(exp_ack0));
        check_eq("ack1_pulses", 32'(ack1_seen), 32'(exp_ack1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
